// File: rtl/psum_pkg.sv
// Shared types and constants for the column partial-sum drain accumulator.
package psum_pkg;

    localparam int DEF_IN_W  = 24;
    localparam int DEF_ACC_W = 32;

    typedef logic signed [DEF_ACC_W-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } psum_state_t;

    // Widen a PE partial sum to accumulator width, preserving sign.
    function automatic acc_t sext(input logic signed [DEF_IN_W-1:0] v);
        return acc_t'(v);
    endfunction

endpackage

// File: rtl/psum_drain_accumulator_if.sv
// Partial-sum input stream and result output stream of one column drain.
interface psum_drain_accumulator_if
    import psum_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic signed [IN_W-1:0]  i_sum;
    logic                    i_valid;
    logic                    i_last;
    logic                    o_in_ready;
    logic signed [ACC_W-1:0] o_data;
    logic                    o_valid;
    logic                    i_ready;

    // Environment side: column PE upstream plus writeback downstream.
    modport master (
        output i_sum, i_valid, i_last, i_ready,
        input  o_in_ready, o_data, o_valid
    );

    // Accumulator side.
    modport slave (
        input  i_sum, i_valid, i_last, i_ready,
        output o_in_ready, o_data, o_valid
    );
endinterface

// File: rtl/psum_result_fifo.sv
// Small synchronous result FIFO with a registered head word.
// head is loaded with the entry that will be at the front after this edge,
// so the output stays stable while the consumer stalls.
module psum_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] count, count_n;
    logic [W-1:0]  head_n;
    logic          do_push, do_pop;

    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));

    // Next pointers, occupancy and head; a push into the slot that becomes
    // the new front is forwarded straight to the head register.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && valid;
        rd_ptr_n = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        count_n  = count + CW'(do_push) - CW'(do_pop);
        head_n   = '0;
        if (count_n != '0) begin
            if (do_push && (wr_ptr == rd_ptr_n))
                head_n = push_data;
            else
                head_n = mem[rd_ptr_n];
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            head   <= head_n;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/psum_drain_accumulator.sv
// Per-column partial-sum drain: accumulates K-tile partial sums and queues
// finished results for writeback.
// Build option: define PSUM_SAT_EN to clamp overflowing results to the
// accumulator range instead of wrapping.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no open result; next accepted beat loads the accumulator
// ST_ACCUM | result open; next accepted beat adds into the accumulator
module psum_drain_accumulator
    import psum_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    psum_drain_accumulator_if.slave bus,
    output logic [CNT_W-1:0]       o_beats,
    output logic                   o_overflow
);
    psum_state_t             state;
    acc_t                    acc;
    acc_t                    base;
    acc_t                    addend;
    acc_t                    result;
    logic signed [DEF_ACC_W:0] wide;
    logic                    ovf;
    logic                    accept;
    logic                    push;
    logic                    fifo_full;

    assign bus.o_in_ready = !fifo_full;
    assign accept         = bus.i_valid && bus.o_in_ready;
    assign push           = accept && bus.i_last;

    // One extra bit exposes signed overflow as a top-two-bit mismatch.
    always_comb begin
        base   = (state == ST_ACCUM) ? acc : '0;
        addend = sext(bus.i_sum);
        wide   = {base[DEF_ACC_W-1], base} + {addend[DEF_ACC_W-1], addend};
        ovf    = wide[DEF_ACC_W] ^ wide[DEF_ACC_W-1];
`ifdef PSUM_SAT_EN
        if (ovf)
            result = wide[DEF_ACC_W] ? ACC_MIN : ACC_MAX;
        else
            result = wide[DEF_ACC_W-1:0];
`else
        result = wide[DEF_ACC_W-1:0];
`endif
    end

    // Open-result state, accumulator, saturating beat count, sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            acc        <= '0;
            o_beats    <= '0;
            o_overflow <= 1'b0;
        end else if (accept) begin
            if (ovf)
                o_overflow <= 1'b1;
            if (bus.i_last) begin
                state   <= ST_EMPTY;
                acc     <= '0;
                o_beats <= '0;
            end else begin
                state <= ST_ACCUM;
                acc   <= result;
                if (o_beats != {CNT_W{1'b1}})
                    o_beats <= o_beats + CNT_W'(1);
            end
        end
    end

    psum_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DEF_ACC_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (result),
        .pop       (bus.i_ready),
        .head      (bus.o_data),
        .valid     (bus.o_valid),
        .full      (fifo_full)
    );
endmodule

// File: tb/tb_psum_drain_accumulator.sv
// Self-checking bench for psum_drain_accumulator: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_psum_drain_accumulator;
    import psum_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] o_beats;
    logic       o_overflow;

    always #5 clock = ~clock;

    psum_drain_accumulator_if bus ();

    psum_drain_accumulator dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .o_beats    (o_beats),
        .o_overflow (o_overflow)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results waiting for writeback, open sum, counters.
    logic [31:0]       q[$];
    longint            macc;
    bit                mopen;
    int                mbeats;
    bit                movf;
    bit                m_pop, m_acc;
    logic signed [23:0] m_x;
    longint            m_sum;
    logic [31:0]       m_w;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            macc = 0; mopen = 0; mbeats = 0; movf = 0;
        end else begin
            m_pop = (q.size() > 0) && (bus.i_ready === 1'b1);
            m_acc = (bus.i_valid === 1'b1) && (q.size() < 4);
            m_x   = bus.i_sum;
            m_sum = (mopen ? macc : 64'sd0) + longint'(m_x);
            m_w   = m_sum[31:0];
            if (m_acc && (m_sum > 64'sd2147483647 || m_sum < -64'sd2147483648)) begin
                movf = 1;
`ifdef PSUM_SAT_EN
                m_w = (m_sum > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                if (bus.i_last === 1'b1) begin
                    q.push_back(m_w);
                    macc = 0; mopen = 0; mbeats = 0;
                end else begin
                    macc  = longint'($signed(m_w));
                    mopen = 1;
                    if (mbeats < 255) mbeats++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en && !reset) begin
            chk("o_valid", 32'(bus.o_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("o_data", bus.o_data, q[0]);
            chk("o_in_ready", 32'(bus.o_in_ready), 32'(q.size() < 4));
            chk("o_beats", 32'(o_beats), 32'(mbeats));
            chk("o_overflow", 32'(o_overflow), 32'(movf));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    // Present a beat and hold it until the accepting edge has passed.
    task automatic send(input logic [23:0] s, input bit l);
        bit done;
        done = 1'b0;
        bus.i_sum   = s;
        bus.i_valid = 1'b1;
        bus.i_last  = l;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            if (bus.o_in_ready === 1'b1) done = 1'b1;
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_sum   = '0;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();

        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_data", bus.o_data, 32'd0);
        chk("rst_o_in_ready", 32'(bus.o_in_ready), 32'd1);
        chk("rst_o_beats", 32'(o_beats), 32'd0);
        chk("rst_o_overflow", 32'(o_overflow), 32'd0);
        cmp_en = 1'b1;

        // 100, -30, 5(last) -> 75
        send(24'd100, 1'b0);
        chk("t1_beats1", 32'(o_beats), 32'd1);
        send(-24'sd30, 1'b0);
        chk("t1_beats2", 32'(o_beats), 32'd2);
        send(24'd5, 1'b1);
        idle();
        chk("t1_beats0", 32'(o_beats), 32'd0);
        chk("t1_valid", 32'(bus.o_valid), 32'd1);
        chk("t1_data", bus.o_data, 32'd75);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk("t1_drained", 32'(bus.o_valid), 32'd0);

        // Most negative single-beat result
        send(24'h800000, 1'b1);
        idle();
        chk("t2_data", bus.o_data, 32'hFF800000);
        chk("t2_model_occ", 32'(q.size()), 32'd1);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // Fill to depth, hold a fifth, free one slot while it waits
        for (int k = 1; k <= 4; k++) send(24'(k), 1'b1);
        idle();
        chk("t3_full_ready", 32'(bus.o_in_ready), 32'd0);
        chk("t3_head1", bus.o_data, 32'd1);
        bus.i_sum   = 24'd5;
        bus.i_valid = 1'b1;
        bus.i_last  = 1'b1;
        tick();
        tick();
        chk("t3_held_ready", 32'(bus.o_in_ready), 32'd0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk("t4_ready_after_pop", 32'(bus.o_in_ready), 32'd1);
        chk("t4_head2", bus.o_data, 32'd2);
        tick();
        idle();
        chk("t4_full_again", 32'(bus.o_in_ready), 32'd0);
        bus.i_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("t3_drain_order", bus.o_data, 32'(k));
            tick();
        end
        bus.i_ready = 1'b0;
        chk("t3_empty", 32'(bus.o_valid), 32'd0);

        // 300 x +8388607: overflow on beat 257, beat count saturates
        for (int i = 1; i <= 300; i++) begin
            send(24'h7FFFFF, i == 300);
            chk("t5_overflow", 32'(o_overflow), 32'(i >= 257));
            if (i == 256 || i == 299) chk("t5_beats_sat", 32'(o_beats), 32'd255);
        end
        idle();
`ifdef PSUM_SAT_EN
        chk("t5_result", bus.o_data, 32'h7FFFFFFF);
`else
        chk("t5_result", bus.o_data, 32'h95FFFED4);
`endif
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // Async reset mid-accumulation with two results queued
        send(24'd10, 1'b1);
        send(24'd20, 1'b1);
        send(24'd1, 1'b0);
        send(24'd2, 1'b0);
        idle();
        #3;
        reset = 1'b1;
        #1;
        chk("t6_o_valid", 32'(bus.o_valid), 32'd0);
        chk("t6_o_data", bus.o_data, 32'd0);
        chk("t6_o_in_ready", 32'(bus.o_in_ready), 32'd1);
        chk("t6_o_beats", 32'(o_beats), 32'd0);
        chk("t6_o_overflow", 32'(o_overflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        send(24'd7, 1'b1);
        idle();
        chk("t6_fresh", bus.o_data, 32'd7);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;

        // Random traffic against the model
        repeat (2000) begin
            bus.i_valid = 1'($urandom_range(0, 1));
            bus.i_last  = ($urandom_range(0, 3) == 0);
            bus.i_sum   = 24'($urandom());
            bus.i_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        idle();
        bus.i_ready = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psum_drain_accumulator.md
Name: psum_drain_accumulator

Overview:
- Sits directly downstream of the bottom PE of each systolic-array column; consumes the column's 24-bit partial-sum stream.
- Accumulates partial sums across K-dimension tiles into a wide accumulator; on the last tile, pushes the final result into a small output FIFO.
- The FIFO drains to the writeback stage over a valid/ready handshake. One instance per column.

Parameters:
- IN_W, 24, width of incoming signed partial sum (matches PE o_sum).
- ACC_W, 32, width of signed accumulator and output result.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- CNT_W, 8, width of per-result beat counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- i_sum  input  IN_W  signed partial sum from column bottom PE.
- i_valid  input  1  i_sum is meaningful this cycle.
- i_last  input  1  qualifies i_valid; the beat is the final tile of the current result.
- o_in_ready  output  1  block can accept a beat; equals NOT fifo_full.
- o_data  output  ACC_W  signed result at FIFO head.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  downstream accepts o_data.
- o_beats  output  CNT_W  beats accumulated into the current open result.
- o_overflow  output  1  sticky: any accumulation exceeded the ACC_W range since reset.

Behaviour:
- Reset (async assert, sync-released usage assumed by system): acc=0, o_beats=0, FIFO empty, o_valid=0, o_data=0, o_in_ready=1, o_overflow=0. Reset mid-accumulation discards the open result and all FIFO contents.
- Beat accepted when i_valid && o_in_ready. A beat with i_valid && !o_in_ready is ignored; the upstream controller must hold or stall the array.
- Internal state: OPEN flag, with two states.
  - EMPTY (o_beats==0): an accepted beat loads acc = sign-extended i_sum.
  - ACCUM (o_beats>0): an accepted beat sets acc = acc + sext(i_sum).
- Accepted beat with i_last=0: o_beats increments; state becomes ACCUM.
- Accepted beat with i_last=1: computed sum (load or add) is pushed into the FIFO the same edge; acc and o_beats return to 0 (EMPTY). A single-beat result (EMPTY + i_last) is legal.
- o_beats saturates at 2^CNT_W-1; it does not wrap. The arithmetic is unaffected.
- Latency: last beat accepted at edge N -> o_valid=1 and o_data valid after edge N (visible cycle N+1) when the FIFO was empty.
- FIFO: pop on o_valid && i_ready. Simultaneous push and pop: both happen; occupancy is unchanged.
- Full: o_in_ready=0 even if a pop occurs that cycle; there is no combinational ready pass-through.
- o_data is registered from the FIFO head; it is stable while o_valid && !i_ready.
- Overflow detection: signed add carry-out mismatch on ACC_W+1-bit intermediate. On overflow, o_overflow is set (sticky until reset).

Optional Feature:
- PSUM_SAT_EN defined: on overflow, the stored result clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)). Further beats accumulate from the clamped value.
- Undefined: two's-complement wrap to ACC_W bits.
- o_overflow behaves identically in both builds.

Decomposition:
- Shared package psum_pkg holds: IN_W/ACC_W defaults; the ACC_MAX/ACC_MIN constants; a sign-extend helper function; an acc_t typedef.
- One sub-module: psum_result_fifo, a synchronous FIFO with registered head, full/empty, and simultaneous push/pop. The accumulator and state logic stay in the top.

Test Plan:
- Beats 100, -30, 5(last) -> one result 75; o_valid on the cycle after the last beat; o_beats sequence 0,1,2,0.
- Single beat -8388608 with last -> result 0xFF800000 (sign-extended); FIFO occupancy 1.
- i_ready=0, push 5 results (1..5) with DEPTH=4 -> o_in_ready drops after 4th. The 5th beat is held by the bench, accepted after one pop. Drained order is 1,2,3,4,5.
- FIFO full, push attempt while popping -> push not accepted that cycle; occupancy goes 4->3; accepted next cycle.
- 300 beats of +8388607 (ACC_W=32) -> o_overflow sets on the overflowing beat.
  - PSUM_SAT_EN defined: result 0x7FFFFFFF.
  - Undefined: wrapped value.
- Reset asserted mid-accumulation (2 beats in, 2 results queued) -> outputs return to reset values immediately (async). Next result starts fresh from EMPTY.
